// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the 7-segment display path: BCD digit width, the
// code the display controller renders as "all segments off", the converter
// FSM state type and a small power-of-ten helper for range limits.
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam int          DIGIT_W    = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bin2bcd_state_t;

    // 10^n, used to derive the largest value representable in n BCD digits.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational correction cell of the shift-and-add-3 algorithm: a BCD
// nibble of 5 or more is bumped by 3 so the following left shift carries
// correctly into the next decimal digit.
//   nib : input BCD nibble
//   adj : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3
    import disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] nib,
    output logic [DIGIT_W-1:0] adj
);

    assign adj = (nib >= DIGIT_W'(5)) ? nib + DIGIT_W'(3) : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Feeds the 7-segment display multiplexer with a stable, registered
// packed BCD word.
//
// Ports:
//   clk      : system clock (27 MHz board clock)
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, only honoured while idle
//   bin      : binary value, captured on the accepted start cycle
//   busy     : high from the accepted start until done drops
//   done     : one-cycle pulse when bcd/overflow update
//   bcd      : packed result, digit 0 (units) in bits [3:0]
//   overflow : input exceeded 10^DIGITS-1; bcd then reads all nines
//
// Optional build macro:
//   BIN2BCD_LEADING_BLANK_EN : replace leading zero digits (never the units
//   digit) with BLANK_CODE when the result is not saturated.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      overflow
);

    localparam int          BCD_W   = DIGIT_W * DIGITS;
    localparam int          WORK_W  = BCD_W + BIN_W;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

    bin2bcd_state_t        state;
    logic [CNT_W-1:0]      cnt;
    logic [WORK_W-1:0]     work;     // {BCD field, binary field}
    logic [BIN_W-1:0]      latched;  // input as captured at start
    logic [BCD_W-1:0]      adj;      // BCD field after add-3 correction
    logic [BCD_W-1:0]      result;
    logic                  over;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib (work[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .adj (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Range check uses the captured input, not the BCD field, which would
    // silently wrap for values beyond the digit count.
    assign over = ({{(32-BIN_W){1'b0}}, latched} > MAX_VAL);

`ifdef BIN2BCD_LEADING_BLANK_EN
    logic lead;
    always_comb begin
        lead   = 1'b1;
        result = work[WORK_W-1:BIN_W];
        if (over) begin
            result = {DIGITS{4'h9}};
        end else begin
            // Walk from the most significant digit; digit 0 stays visible.
            for (int d = DIGITS-1; d >= 1; d--) begin
                if (lead && (result[d*DIGIT_W +: DIGIT_W] == '0)) begin
                    result[d*DIGIT_W +: DIGIT_W] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        result = work[WORK_W-1:BIN_W];
        if (over) begin
            result = {DIGITS{4'h9}};
        end
    end
`endif

    // Datapath: no reset needed, every conversion reloads it at start.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            work    <= {{BCD_W{1'b0}}, bin};
            latched <= bin;
        end else if (state == SHIFT) begin
            work    <= {adj, work[BIN_W-1:0]} << 1;
        end
    end

    // Control FSM with registered outputs. DONE lasts one cycle and the
    // done/busy flags it sets are seen during the following cycle, so the
    // FSM is already back in IDLE and can accept a start on the edge where
    // done and busy drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd      <= result;
                    overflow <= over;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
`timescale 1ns/1ps
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        overflow;

    int n_cmp;
    int n_bad;

`ifdef BIN2BCD_LEADING_BLANK_EN
    localparam logic [11:0] EXP_57  = 12'hF57;
    localparam logic [11:0] EXP_0   = 12'hFF0;
    localparam logic [11:0] EXP_7   = 12'hFF7;
`else
    localparam logic [11:0] EXP_57  = 12'h057;
    localparam logic [11:0] EXP_0   = 12'h000;
    localparam logic [11:0] EXP_7   = 12'h007;
`endif

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #18 clk = ~clk;

    // Pulse start for one cycle with value v, then wait (bounded) for done.
    // lat counts edges after the start edge; -1 means done never came.
    task automatic run_conv(input logic [9:0] v, output int lat,
                            output logic [11:0] b, output logic o,
                            output logic busy_e0, output logic done_after,
                            output logic busy_after);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        start   = 1'b0;
        bin     = ~v;
        busy_e0 = busy;
        lat     = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
        b = bcd;
        o = overflow;
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (bcd !== 12'h000)   begin n_bad++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic [11:0] b; logic o, be0, da, ba;
        run_conv(10'd57, lat, b, o, be0, da, ba);
        n_cmp++; if (lat !== 11)   begin n_bad++; $display("FAIL b57_latency got=%0d exp=11", lat); end
        n_cmp++; if (b !== EXP_57) begin n_bad++; $display("FAIL b57_bcd got=%h exp=%h", b, EXP_57); end
        n_cmp++; if (o !== 1'b0)   begin n_bad++; $display("FAIL b57_ovf got=%b exp=0", o); end
        n_cmp++; if (be0 !== 1'b1) begin n_bad++; $display("FAIL b57_busy_e0 got=%b exp=1", be0); end
        n_cmp++; if (da !== 1'b0)  begin n_bad++; $display("FAIL b57_done_pulse got=%b exp=0", da); end
        n_cmp++; if (ba !== 1'b0)  begin n_bad++; $display("FAIL b57_busy_after got=%b exp=0", ba); end
        n_cmp++; if (bcd !== EXP_57) begin n_bad++; $display("FAIL b57_bcd_hold got=%h exp=%h", bcd, EXP_57); end
    endtask

    task automatic test_small();
        int lat; logic [11:0] b; logic o, be0, da, ba;
        run_conv(10'd0, lat, b, o, be0, da, ba);
        n_cmp++; if (b !== EXP_0) begin n_bad++; $display("FAIL b0_bcd got=%h exp=%h", b, EXP_0); end
        n_cmp++; if (o !== 1'b0)  begin n_bad++; $display("FAIL b0_ovf got=%b exp=0", o); end
        run_conv(10'd7, lat, b, o, be0, da, ba);
        n_cmp++; if (b !== EXP_7) begin n_bad++; $display("FAIL b7_bcd got=%h exp=%h", b, EXP_7); end
    endtask

    task automatic test_overflow();
        int lat; logic [11:0] b; logic o, be0, da, ba;
        run_conv(10'd999, lat, b, o, be0, da, ba);
        n_cmp++; if (b !== 12'h999) begin n_bad++; $display("FAIL b999_bcd got=%h exp=999", b); end
        n_cmp++; if (o !== 1'b0)    begin n_bad++; $display("FAIL b999_ovf got=%b exp=0", o); end
        run_conv(10'd1023, lat, b, o, be0, da, ba);
        n_cmp++; if (lat !== 11)    begin n_bad++; $display("FAIL b1023_latency got=%0d exp=11", lat); end
        n_cmp++; if (b !== 12'h999) begin n_bad++; $display("FAIL b1023_bcd got=%h exp=999", b); end
        n_cmp++; if (o !== 1'b1)    begin n_bad++; $display("FAIL b1023_ovf got=%b exp=1", o); end
        run_conv(10'd1000, lat, b, o, be0, da, ba);
        n_cmp++; if (b !== 12'h999) begin n_bad++; $display("FAIL b1000_bcd got=%h exp=999", b); end
        n_cmp++; if (o !== 1'b1)    begin n_bad++; $display("FAIL b1000_ovf got=%b exp=1", o); end
    endtask

    task automatic test_ignore_start();
        int pulses; int lat; logic [11:0] b; logic o, be0, da, ba;
        start = 1'b1;
        bin   = 10'd321;
        @(posedge clk); #1;
        start  = 1'b0;
        bin    = 10'd0;
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (c == 3)  begin start = 1'b1; bin = 10'd100; end
            if (c == 4)  start = 1'b0;
            if (c == 10) begin start = 1'b1; bin = 10'd100; end
            if (c == 11) start = 1'b0;
        end
        n_cmp++; if (pulses !== 1)    begin n_bad++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
        n_cmp++; if (bcd !== 12'h321) begin n_bad++; $display("FAIL ign_bcd got=%h exp=321", bcd); end
        run_conv(10'd100, lat, b, o, be0, da, ba);
        n_cmp++; if (b !== 12'h100)   begin n_bad++; $display("FAIL ign_fresh_bcd got=%h exp=100", b); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [11:0] b; logic o, be0, da, ba;
        start = 1'b1;
        bin   = 10'd700;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL rmid_done got=%b exp=0", done); end
        n_cmp++; if (bcd !== 12'h000)   begin n_bad++; $display("FAIL rmid_bcd got=%h exp=000", bcd); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_conv(10'd123, lat, b, o, be0, da, ba);
        n_cmp++; if (lat !== 11)    begin n_bad++; $display("FAIL rmid_latency got=%0d exp=11", lat); end
        n_cmp++; if (b !== 12'h123) begin n_bad++; $display("FAIL rmid_bcd_after got=%h exp=123", b); end
    endtask

    task automatic test_back_to_back();
        int times[$];
        bit drained;
        start = 1'b1;
        bin   = 10'd456;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                times.push_back(c);
                n_cmp++; if (bcd !== 12'h456) begin n_bad++; $display("FAIL b2b_bcd at=%0d got=%h exp=456", c, bcd); end
            end
        end
        start = 1'b0;
        n_cmp++; if (times.size() !== 3) begin n_bad++; $display("FAIL b2b_count got=%0d exp=3", times.size()); end
        if (times.size() >= 1) begin
            n_cmp++; if (times[0] !== 11) begin n_bad++; $display("FAIL b2b_first got=%0d exp=11", times[0]); end
        end
        for (int i = 1; i < times.size(); i++) begin
            n_cmp++;
            if (times[i] - times[i-1] !== 12) begin
                n_bad++; $display("FAIL b2b_period got=%0d exp=12", times[i] - times[i-1]);
            end
        end
        drained = 1'b0;
        for (int c = 0; c < 30 && !drained; c++) begin
            @(posedge clk); #1;
            if (!busy) drained = 1'b1;
        end
        n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL b2b_drain got=%b exp=1", drained); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_small();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
